micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer_pkg.sv | 22 ++
 rtl/micro_sequencer_stack.sv | 52 +++++
 rtl/micro_sequencer.sv | 105 ++++++++++
 tb/tb_micro_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared constants for the micro-sequencer: opcode set, FSM states and default widths.
package micro_sequencer_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 11;

  typedef enum logic [2:0] {
    OP_NEXT    = 3'b000,
    OP_JUMP    = 3'b001,
    OP_BRT     = 3'b010,
    OP_BRF     = 3'b011,
    OP_CALL    = 3'b100,
    OP_RET     = 3'b101,
    OP_HOLD    = 3'b110,
    OP_RESTART = 3'b111
  } seq_op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/micro_sequencer_stack.sv
// Return-address LIFO; the reset and clear inputs empty it by zeroing depth only.
module micro_sequencer_stack #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        push_data_i,
  output logic [WIDTH-1:0]        top_c_o,
  output logic [$clog2(DEPTH):0]  depth_o,
  output logic                    full_c_o,
  output logic                    empty_c_o
);

  localparam int unsigned DW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  assign wr_idx    = IW'(depth_q);
  assign rd_idx    = IW'(depth_q - DW'(1));
  assign top_c_o   = mem_q[rd_idx];
  assign full_c_o  = (depth_q == DW'(DEPTH));
  assign empty_c_o = (depth_q == '0);
  assign depth_o   = depth_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      depth_q <= '0;
    end else if (clr_i) begin
      depth_q <= '0;
    end else if (push_i) begin
      depth_q <= depth_q + DW'(1);
    end else if (pop_i) begin
      depth_q <= depth_q - DW'(1);
    end
  end

  // Storage carries no reset: stale entries are unreachable once depth is zero.
  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i && !clr_i) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Control-store address sequencer: next-address decode, RUN/FAULT FSM and call stack.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned Direction_BUS_WIDTH = ADDR_W_DEFAULT,
  parameter int unsigned STACK_DEPTH         = 4
) (
  input  logic                            MICRO_SEQUENCER_CLOCK_50,
  input  logic                            MICRO_SEQUENCER_RESET_InHigh,
  input  logic [2:0]                      MICRO_SEQUENCER_Op_IN,
  input  logic [Direction_BUS_WIDTH-1:0]  MICRO_SEQUENCER_Target_IN,
  input  logic                            MICRO_SEQUENCER_Cond_IN,
  input  logic                            MICRO_SEQUENCER_Stall_IN,
  output logic [Direction_BUS_WIDTH-1:0]  MICRO_SEQUENCER_Direccion_OUT,
  output logic [$clog2(STACK_DEPTH):0]    MICRO_SEQUENCER_Depth_OUT,
  output logic                            MICRO_SEQUENCER_Error_OUT
);

  localparam int unsigned AW = Direction_BUS_WIDTH;

  seq_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic [AW-1:0] incr;
  logic          push_c, pop_c, clr_c;
  logic [AW-1:0] top_c;
  logic          full_c, empty_c;
  seq_op_e       op;

  assign incr = addr_q + AW'(1);
  assign op   = seq_op_e'(MICRO_SEQUENCER_Op_IN);

  micro_sequencer_stack #(
    .WIDTH (AW),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i       (MICRO_SEQUENCER_CLOCK_50),
    .rst_i       (MICRO_SEQUENCER_RESET_InHigh),
    .clr_i       (clr_c),
    .push_i      (push_c),
    .pop_i       (pop_c),
    .push_data_i (incr),
    .top_c_o     (top_c),
    .depth_o     (MICRO_SEQUENCER_Depth_OUT),
    .full_c_o    (full_c),
    .empty_c_o   (empty_c)
  );

  // Next-address decode; stall and FAULT both leave everything as is.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    clr_c   = 1'b0;
    if (state_q == ST_RUN && !MICRO_SEQUENCER_Stall_IN) begin
      case (op)
        OP_NEXT: addr_d = incr;
        OP_JUMP: addr_d = MICRO_SEQUENCER_Target_IN;
        OP_BRT:  addr_d = MICRO_SEQUENCER_Cond_IN ? MICRO_SEQUENCER_Target_IN : incr;
        OP_BRF:  addr_d = MICRO_SEQUENCER_Cond_IN ? incr : MICRO_SEQUENCER_Target_IN;
        OP_CALL: begin
          if (full_c) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
          end else begin
            push_c = 1'b1;
            addr_d = MICRO_SEQUENCER_Target_IN;
          end
        end
        OP_RET: begin
          if (empty_c) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
          end else begin
            pop_c  = 1'b1;
            addr_d = top_c;
          end
        end
        OP_RESTART: begin
          addr_d = '0;
          clr_c  = 1'b1;
        end
        default: addr_d = addr_q;
      endcase
    end
  end

  always_ff @(posedge MICRO_SEQUENCER_CLOCK_50) begin
    if (MICRO_SEQUENCER_RESET_InHigh) begin
      state_q <= ST_RUN;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign MICRO_SEQUENCER_Direccion_OUT = addr_q;
  assign MICRO_SEQUENCER_Error_OUT     = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios plus random ops against a queue-based model.
module tb_micro_sequencer;

  localparam int AW    = 11;
  localparam int DEPTH = 4;
  localparam int SPAN  = 2048;

  logic          clk;
  logic          rst;
  logic [2:0]    op;
  logic [AW-1:0] tgt;
  logic          cond;
  logic          stall;
  logic [AW-1:0] addr_o;
  logic [2:0]    depth_o;
  logic          err_o;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  int m_addr;
  int m_stack[$];
  bit m_err;
  bit m_fault;

  micro_sequencer dut (
    .MICRO_SEQUENCER_CLOCK_50      (clk),
    .MICRO_SEQUENCER_RESET_InHigh  (rst),
    .MICRO_SEQUENCER_Op_IN         (op),
    .MICRO_SEQUENCER_Target_IN     (tgt),
    .MICRO_SEQUENCER_Cond_IN       (cond),
    .MICRO_SEQUENCER_Stall_IN      (stall),
    .MICRO_SEQUENCER_Direccion_OUT (addr_o),
    .MICRO_SEQUENCER_Depth_OUT     (depth_o),
    .MICRO_SEQUENCER_Error_OUT     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one microinstruction, let an edge consume it, then advance the model.
  task automatic step(input int s_op, input int s_tgt, input bit s_cond,
                      input bit s_stall, input bit s_rst);
    op    = 3'(s_op);
    tgt   = AW'(s_tgt);
    cond  = s_cond;
    stall = s_stall;
    rst   = s_rst;
    @(posedge clk);
    if (s_rst) begin
      m_addr = 0;
      m_stack.delete();
      m_err = 0;
      m_fault = 0;
    end else if (!s_stall && !m_fault) begin
      case (s_op)
        0: m_addr = (m_addr + 1) % SPAN;
        1: m_addr = s_tgt % SPAN;
        2: m_addr = s_cond ? s_tgt % SPAN : (m_addr + 1) % SPAN;
        3: m_addr = !s_cond ? s_tgt % SPAN : (m_addr + 1) % SPAN;
        4: begin
          if (m_stack.size() == DEPTH) begin
            m_err = 1;
            m_fault = 1;
          end else begin
            m_stack.push_back((m_addr + 1) % SPAN);
            m_addr = s_tgt % SPAN;
          end
        end
        5: begin
          if (m_stack.size() == 0) begin
            m_err = 1;
            m_fault = 1;
          end else begin
            m_addr = m_stack.pop_back();
          end
        end
        7: begin
          m_addr = 0;
          m_stack.delete();
        end
        default: ;
      endcase
    end
    chk_en = 1;
    @(negedge clk);
  endtask

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 3;
      if (int'(addr_o) != m_addr) begin
        failures++;
        $display("FAIL model_addr t=%0t got=%0d exp=%0d", $time, addr_o, m_addr);
      end
      if (int'(depth_o) != m_stack.size()) begin
        failures++;
        $display("FAIL model_depth t=%0t got=%0d exp=%0d", $time, depth_o, m_stack.size());
      end
      if (err_o != m_err) begin
        failures++;
        $display("FAIL model_err t=%0t got=%0d exp=%0d", $time, err_o, m_err);
      end
    end
  end

  // Hand-computed expectation, checked against both the DUT and the model.
  task automatic lit(input string name, input int e_addr, input int e_depth, input int e_err);
    checks += 2;
    if (int'(addr_o) != e_addr || int'(depth_o) != e_depth || int'(err_o) != e_err) begin
      failures++;
      $display("FAIL %s dut addr/depth/err=%0d/%0d/%0d exp=%0d/%0d/%0d",
               name, addr_o, depth_o, err_o, e_addr, e_depth, e_err);
    end
    if (m_addr != e_addr || m_stack.size() != e_depth || int'(m_err) != e_err) begin
      failures++;
      $display("FAIL %s model addr/depth/err=%0d/%0d/%0d exp=%0d/%0d/%0d",
               name, m_addr, m_stack.size(), m_err, e_addr, e_depth, e_err);
    end
  endtask

  initial begin
    int r;
    int rop;
    op = 3'd0; tgt = '0; cond = 1'b0; stall = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Reset then sequential fetch and address wrap.
    step(6, 0, 0, 1, 1);
    lit("reset", 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 0, 0);
      lit("next", i, 0, 0);
    end
    step(1, 2047, 0, 0, 0);
    lit("jump_max", 2047, 0, 0);
    step(0, 0, 0, 0, 0);
    lit("wrap", 0, 0, 0);

    // Branches.
    step(1, 10, 0, 0, 0);
    step(2, 100, 1, 0, 0);
    lit("brt_taken", 100, 0, 0);
    step(1, 10, 0, 0, 0);
    step(2, 100, 0, 0, 0);
    lit("brt_not_taken", 11, 0, 0);
    step(1, 10, 0, 0, 0);
    step(3, 50, 0, 0, 0);
    lit("brf_taken", 50, 0, 0);

    // Nested calls.
    step(1, 20, 0, 0, 0);
    step(4, 200, 0, 0, 0);
    lit("call1", 200, 1, 0);
    step(4, 300, 0, 0, 0);
    lit("call2", 300, 2, 0);
    step(5, 0, 0, 0, 0);
    lit("ret1", 201, 1, 0);
    step(5, 0, 0, 0, 0);
    lit("ret2", 21, 0, 0);

    // Underflow fault is sticky until reset.
    step(5, 0, 0, 0, 0);
    lit("underflow", 21, 0, 1);
    step(1, 5, 0, 0, 0);
    lit("fault_jump", 21, 0, 1);
    step(7, 0, 0, 0, 0);
    lit("fault_restart", 21, 0, 1);
    step(0, 0, 0, 0, 1);
    lit("fault_reset", 0, 0, 0);

    // Fill the stack, then overflow.
    for (int i = 1; i <= 4; i++) begin
      step(4, 100 * i, 0, 0, 0);
    end
    lit("fill", 400, 4, 0);
    step(4, 500, 0, 0, 0);
    lit("overflow", 400, 4, 1);
    step(0, 0, 0, 0, 1);

    // Stall freezes a CALL; reset discards a CALL.
    step(1, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(4, 400, 1, 1, 0);
      lit("stall_call", 7, 0, 0);
    end
    step(4, 400, 0, 0, 0);
    lit("call_after_stall", 400, 1, 0);
    step(4, 600, 0, 0, 1);
    lit("reset_mid_call", 0, 0, 0);
    step(0, 0, 0, 0, 0);
    lit("resume", 1, 0, 0);

    // Randomised traffic.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 18) rop = 0;
      else if (r < 28) rop = 1;
      else if (r < 38) rop = 2;
      else if (r < 48) rop = 3;
      else if (r < 66) rop = 4;
      else if (r < 84) rop = 5;
      else if (r < 92) rop = 6;
      else rop = 7;
      step(rop, $urandom_range(0, SPAN - 1), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) == 0) || (m_fault && $urandom_range(0, 3) == 0));
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
